// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Opcodes, branch/jump codes, PC source encodings and control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GE   = 3'b100;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_JAL  = 2'b01;
  localparam logic [1:0] J_JALR = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic [1:0] jump;
    logic [2:0] branch;
    logic [2:0] alucontrol;
    logic       alusrc;
    logic       lui;
  } ctrl_t;

endpackage

// File: rtl/branch_resolve.sv
// E-stage branch/jump resolution.
// Picks the next-PC source; a bubble never redirects.
module branch_resolve
  import riscv_pkg::*;
(
  input  logic [2:0] BranchE,
  input  logic [1:0] JumpE,
  input  logic       validE,
  input  logic       zeroE,
  input  logic       ltE,
  output logic [1:0] PCSrcE,
  output logic       takenE
);

  logic br_hit;
  logic jal;
  logic jalr;
  logic br_take;

  // condition met for the registered branch code
  always_comb begin
    br_hit = 1'b0;
    case (BranchE)
      BR_EQ:   br_hit = zeroE;
      BR_NE:   br_hit = !zeroE;
      BR_LT:   br_hit = ltE;
      BR_GE:   br_hit = !ltE;
      default: br_hit = 1'b0;
    endcase
  end

  assign jal     = validE && (JumpE == J_JAL);
  assign jalr    = validE && (JumpE == J_JALR);
  assign br_take = validE && (JumpE == J_NONE) && br_hit;

  // jumps override any branch code
  always_comb begin
    PCSrcE = PC_PLUS4;
    unique case (1'b1)
      jal:     PCSrcE = PC_TARGET;
      jalr:    PCSrcE = PC_ALU;
      br_take: PCSrcE = PC_TARGET;
      default: PCSrcE = PC_PLUS4;
    endcase
  end

  assign takenE = (PCSrcE != PC_PLUS4);

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register.
// Stall holds, flush inserts a counted bubble, E resolves branches.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             regWriteD,
  input  logic             memWriteD,
  input  logic             AluSrcD,
  input  logic             luiD,
  input  logic [1:0]       resultSrcD,
  input  logic [1:0]       JumpD,
  input  logic [2:0]       BranchD,
  input  logic [2:0]       aluControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             zeroE,
  input  logic             ltE,
  output logic             regWriteE,
  output logic             memWriteE,
  output logic             AluSrcE,
  output logic             luiE,
  output logic [1:0]       resultSrcE,
  output logic [1:0]       JumpE,
  output logic [2:0]       BranchE,
  output logic [2:0]       aluControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             validE,
  output logic [1:0]       PCSrcE,
  output logic             takenE,
  output logic [CNT_W-1:0] bubbleCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t ctrl_d;
  ctrl_t ctrl_e;

  // pack decoder controls into the shared bundle
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.regwrite   = regWriteD;
    ctrl_d.resultsrc  = resultSrcD;
    ctrl_d.memwrite   = memWriteD;
    ctrl_d.jump       = JumpD;
    ctrl_d.branch     = BranchD;
    ctrl_d.alucontrol = aluControlD;
    ctrl_d.alusrc     = AluSrcD;
    ctrl_d.lui        = luiD;
  end

  // E register: reset > flush (bubble) > stall (hold) > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e    <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      PCE       <= '0;
      ImmExtE   <= '0;
      PCPlus4E  <= '0;
      Rs1E      <= '0;
      Rs2E      <= '0;
      RdE       <= '0;
      validE    <= 1'b0;
      bubbleCnt <= '0;
    end else if (flushE) begin
      ctrl_e   <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      validE   <= 1'b0;
      if (bubbleCnt != CNT_MAX)
        bubbleCnt <= bubbleCnt + CNT_ONE;
    end else if (!stallE) begin
      ctrl_e   <= ctrl_d;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      validE   <= 1'b1;
    end
  end

  assign regWriteE   = ctrl_e.regwrite;
  assign memWriteE   = ctrl_e.memwrite;
  assign AluSrcE     = ctrl_e.alusrc;
  assign luiE        = ctrl_e.lui;
  assign resultSrcE  = ctrl_e.resultsrc;
  assign JumpE       = ctrl_e.jump;
  assign BranchE     = ctrl_e.branch;
  assign aluControlE = ctrl_e.alucontrol;

  branch_resolve u_br (
    .BranchE (BranchE),
    .JumpE   (JumpE),
    .validE  (validE),
    .zeroE   (zeroE),
    .ltE     (ltE),
    .PCSrcE  (PCSrcE),
    .takenE  (takenE)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst, stallE, flushE;
  logic regWriteD, memWriteD, AluSrcD, luiD;
  logic [1:0] resultSrcD, JumpD;
  logic [2:0] BranchD, aluControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic zeroE, ltE;

  logic regWriteE, memWriteE, AluSrcE, luiE;
  logic [1:0] resultSrcE, JumpE;
  logic [2:0] BranchE, aluControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic validE, takenE;
  logic [1:0] PCSrcE;
  logic [15:0] bubbleCnt;

  logic s_regWriteE, s_memWriteE, s_AluSrcE, s_luiE;
  logic [1:0] s_resultSrcE, s_JumpE;
  logic [2:0] s_BranchE, s_aluControlE;
  logic [31:0] s_RD1E, s_RD2E, s_PCE, s_ImmExtE, s_PCPlus4E;
  logic [4:0] s_Rs1E, s_Rs2E, s_RdE;
  logic s_validE, s_takenE;
  logic [1:0] s_PCSrcE;
  logic [1:0] s_bubbleCnt;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
    .regWriteD(regWriteD), .memWriteD(memWriteD),
    .AluSrcD(AluSrcD), .luiD(luiD),
    .resultSrcD(resultSrcD), .JumpD(JumpD),
    .BranchD(BranchD), .aluControlD(aluControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .zeroE(zeroE), .ltE(ltE),
    .regWriteE(regWriteE), .memWriteE(memWriteE),
    .AluSrcE(AluSrcE), .luiE(luiE),
    .resultSrcE(resultSrcE), .JumpE(JumpE),
    .BranchE(BranchE), .aluControlE(aluControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .validE(validE), .PCSrcE(PCSrcE), .takenE(takenE),
    .bubbleCnt(bubbleCnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) sat (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
    .regWriteD(regWriteD), .memWriteD(memWriteD),
    .AluSrcD(AluSrcD), .luiD(luiD),
    .resultSrcD(resultSrcD), .JumpD(JumpD),
    .BranchD(BranchD), .aluControlD(aluControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .zeroE(zeroE), .ltE(ltE),
    .regWriteE(s_regWriteE), .memWriteE(s_memWriteE),
    .AluSrcE(s_AluSrcE), .luiE(s_luiE),
    .resultSrcE(s_resultSrcE), .JumpE(s_JumpE),
    .BranchE(s_BranchE), .aluControlE(s_aluControlE),
    .RD1E(s_RD1E), .RD2E(s_RD2E), .PCE(s_PCE),
    .ImmExtE(s_ImmExtE), .PCPlus4E(s_PCPlus4E),
    .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE),
    .validE(s_validE), .PCSrcE(s_PCSrcE), .takenE(s_takenE),
    .bubbleCnt(s_bubbleCnt)
  );

  // the hazard unit (this bench) must never stall E during a redirect
  always @(negedge clk)
    if (!rst && takenE && stallE)
      $error("stallE asserted while takenE is high");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    regWriteD = 0; memWriteD = 0; AluSrcD = 0; luiD = 0;
    resultSrcD = 0; JumpD = 0; BranchD = 0; aluControlD = 0;
    RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  task automatic test_reset();
    rst = 1; stallE = 0; flushE = 0; zeroE = 0; ltE = 0;
    clear_d();
    tick();
    rst = 0;
    total++;
    if (validE !== 1'b0) $display("FAIL reset_valid got %b want 0", validE);
    else pass++;
    total++;
    if (RdE !== 5'd0 || regWriteE !== 1'b0)
      $display("FAIL reset_regs got rd=%0d rw=%b want 0/0", RdE, regWriteE);
    else pass++;
    total++;
    if (bubbleCnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", bubbleCnt);
    else pass++;
    total++;
    if (PCSrcE !== 2'b00 || takenE !== 1'b0)
      $display("FAIL reset_pcsrc got %b/%b want 00/0", PCSrcE, takenE);
    else pass++;
  endtask

  task automatic test_capture();
    RdD = 5; regWriteD = 1; RD1D = 32'h1234; PCD = 32'h100;
    tick();
    clear_d();
    total++;
    if (RdE !== 5'd5) $display("FAIL cap_rd got %0d want 5", RdE);
    else pass++;
    total++;
    if (regWriteE !== 1'b1) $display("FAIL cap_rw got %b want 1", regWriteE);
    else pass++;
    total++;
    if (RD1E !== 32'h1234) $display("FAIL cap_rd1 got %h want 00001234", RD1E);
    else pass++;
    total++;
    if (validE !== 1'b1 || PCE !== 32'h100)
      $display("FAIL cap_valid got v=%b pc=%h want 1/00000100", validE, PCE);
    else pass++;
  endtask

  task automatic test_stall();
    RdD = 7; RD2D = 32'hAAAA; memWriteD = 1;
    tick();
    stallE = 1;
    for (int i = 0; i < 3; i++) begin
      RdD = 5'(i + 10); RD2D = i; memWriteD = 0; regWriteD = 1;
      tick();
      total++;
      if (RdE !== 5'd7 || RD2E !== 32'hAAAA || memWriteE !== 1'b1 ||
          regWriteE !== 1'b0 || validE !== 1'b1)
        $display("FAIL stall_hold[%0d] got rd=%0d rd2=%h mw=%b rw=%b v=%b want 7/0000aaaa/1/0/1",
                 i, RdE, RD2E, memWriteE, regWriteE, validE);
      else pass++;
      total++;
      if (bubbleCnt !== 16'd0) $display("FAIL stall_cnt[%0d] got %0d want 0", i, bubbleCnt);
      else pass++;
    end
    stallE = 0;
    clear_d();
  endtask

  task automatic test_flush_over_stall();
    flushE = 1; stallE = 1; regWriteD = 1; memWriteD = 1; RdD = 9;
    JumpD = 2'b01; BranchD = 3'b001; aluControlD = 3'b101; RD1D = 32'hFF;
    tick();
    flushE = 0; stallE = 0;
    clear_d();
    total++;
    if (regWriteE !== 0 || memWriteE !== 0 || JumpE !== 0 || BranchE !== 0 ||
        aluControlE !== 0)
      $display("FAIL flush_ctrl got rw=%b mw=%b j=%b b=%b alu=%b want all 0",
               regWriteE, memWriteE, JumpE, BranchE, aluControlE);
    else pass++;
    total++;
    if (RdE !== 5'd0 || RD1E !== 32'd0)
      $display("FAIL flush_data got rd=%0d rd1=%h want 0/0", RdE, RD1E);
    else pass++;
    total++;
    if (validE !== 1'b0) $display("FAIL flush_valid got %b want 0", validE);
    else pass++;
    total++;
    if (bubbleCnt !== 16'd1) $display("FAIL flush_cnt got %0d want 1", bubbleCnt);
    else pass++;
  endtask

  task automatic test_branch();
    logic [2:0] br  [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b111, 3'b000, 3'b001};
    logic [1:0] jp  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    logic       zf  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       lf  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp [8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) begin
      BranchD = br[i]; JumpD = jp[i];
      tick();
      clear_d();
      zeroE = zf[i]; ltE = lf[i];
      #1;
      total++;
      if (PCSrcE !== exp[i] || takenE !== (exp[i] != 2'b00))
        $display("FAIL branch[%0d] got pcsrc=%b taken=%b want %b/%b",
                 i, PCSrcE, takenE, exp[i], exp[i] != 2'b00);
      else pass++;
    end
    zeroE = 0; ltE = 0;
  endtask

  task automatic test_bubble_mask();
    JumpD = 2'b01; BranchD = 3'b001; flushE = 1;
    tick();
    flushE = 0;
    clear_d();
    zeroE = 1;
    #1;
    total++;
    if (PCSrcE !== 2'b00 || takenE !== 1'b0 || JumpE !== 2'b00)
      $display("FAIL bubble_mask got pcsrc=%b taken=%b j=%b want 00/0/00",
               PCSrcE, takenE, JumpE);
    else pass++;
    total++;
    if (bubbleCnt !== 16'd2) $display("FAIL bubble_cnt2 got %0d want 2", bubbleCnt);
    else pass++;
    zeroE = 0;
  endtask

  task automatic test_saturation();
    logic [1:0] sexp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1;
    tick();
    rst = 0;
    flushE = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (s_bubbleCnt !== sexp[i])
        $display("FAIL sat_cnt[%0d] got %0d want %0d", i, s_bubbleCnt, sexp[i]);
      else pass++;
      total++;
      if (bubbleCnt !== 16'(i + 1))
        $display("FAIL wide_cnt[%0d] got %0d want %0d", i, bubbleCnt, i + 1);
      else pass++;
    end
    flushE = 0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] rd [3] = '{5'd3, 5'd17, 5'd31};
    for (int i = 0; i < 3; i++) begin
      RdD = rd[i]; ImmExtD = 32'h10 * (i + 1);
      tick();
      total++;
      if (RdE !== rd[i] || ImmExtE !== 32'h10 * (i + 1) || validE !== 1'b1)
        $display("FAIL b2b[%0d] got rd=%0d imm=%h v=%b want %0d/%h/1",
                 i, RdE, ImmExtE, validE, rd[i], 32'h10 * (i + 1));
      else pass++;
    end
    clear_d();
  endtask

  task automatic test_reset_mid();
    JumpD = 2'b01; RdD = 4;
    tick();
    clear_d();
    total++;
    if (PCSrcE !== 2'b01 || takenE !== 1'b1)
      $display("FAIL mid_jal got pcsrc=%b taken=%b want 01/1", PCSrcE, takenE);
    else pass++;
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (PCSrcE !== 2'b00 || validE !== 1'b0 || bubbleCnt !== 16'd0 || RdE !== 5'd0)
      $display("FAIL mid_reset got pcsrc=%b v=%b cnt=%0d rd=%0d want 00/0/0/0",
               PCSrcE, validE, bubbleCnt, RdE);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_stall();
    test_flush_over_stall();
    test_branch();
    test_bubble_mask();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
